// File: rtl/jpeg_axis_packer.sv
// rtl/jpeg_axis_packer.sv - packs an 8-bit JPEG byte stream into 32-bit little-endian words for DMA
// Optional end-of-image (FF D9) check enabled by defining JPEG_PACKER_EOI_CHECK_EN.
module jpeg_axis_packer #(
  parameter int CNT_W = 24
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [7:0]       s_axis_tdata,
  input  logic             s_axis_tvalid,
  output logic             s_axis_tready,
  input  logic             s_axis_tlast,
  input  logic             s_axis_tuser,
  output logic [31:0]      m_axis_tdata,
  output logic [3:0]       m_axis_tkeep,
  output logic             m_axis_tvalid,
  input  logic             m_axis_tready,
  output logic             m_axis_tlast,
  output logic             m_axis_tuser,
  output logic             frame_done,
  output logic [CNT_W-1:0] frame_len,
  output logic             proto_err,
  output logic             eoi_err
);

  typedef enum logic {S_IDLE, S_IN_FRAME} state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [1:0]       r_lane;
  logic [23:0]      r_buf;
  logic             r_buf_user;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] r_frame_len;
  logic             r_frame_done;
  logic             r_proto_err;
  logic [31:0]      r_m_tdata;
  logic [3:0]       r_m_tkeep;
  logic             r_m_tvalid;
  logic             r_m_tlast;
  logic             r_m_tuser;

  logic             w_accept;
  logic             w_word_end;
  logic             w_proto;
  logic [CNT_W-1:0] w_cnt_inc;
  logic [31:0]      w_word;
  logic [3:0]       w_keep;

  assign s_axis_tready = !r_m_tvalid || m_axis_tready;
  assign w_accept      = s_axis_tvalid && s_axis_tready;
  assign w_word_end    = (r_lane == 2'd3) || s_axis_tlast;
  assign w_proto       = s_axis_tuser ? ((r_state == S_IN_FRAME) || (r_lane != 2'd0))
                                      : (r_state == S_IDLE);
  assign w_cnt_inc     = (&r_cnt) ? r_cnt : r_cnt + {{(CNT_W-1){1'b0}}, 1'b1};

  assign m_axis_tdata  = r_m_tdata;
  assign m_axis_tkeep  = r_m_tkeep;
  assign m_axis_tvalid = r_m_tvalid;
  assign m_axis_tlast  = r_m_tlast;
  assign m_axis_tuser  = r_m_tuser;
  assign frame_done    = r_frame_done;
  assign frame_len     = r_frame_len;
  assign proto_err     = r_proto_err;

  // Stale bytes above the current lane are never forwarded, so unused lanes read as zero.
  always_comb begin
    w_word = 32'd0;
    w_keep = 4'b0000;
    case (r_lane)
      2'd0: begin w_word = {24'd0, s_axis_tdata};              w_keep = 4'b0001; end
      2'd1: begin w_word = {16'd0, s_axis_tdata, r_buf[7:0]};  w_keep = 4'b0011; end
      2'd2: begin w_word = {8'd0, s_axis_tdata, r_buf[15:0]};  w_keep = 4'b0111; end
      default: begin w_word = {s_axis_tdata, r_buf[23:0]};     w_keep = 4'b1111; end
    endcase
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:     if (w_accept && !s_axis_tlast) w_state_nxt = S_IN_FRAME;
      S_IN_FRAME: if (w_accept && s_axis_tlast)  w_state_nxt = S_IDLE;
      default:    w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_lane       <= 2'd0;
      r_buf        <= 24'd0;
      r_buf_user   <= 1'b0;
      r_cnt        <= '0;
      r_frame_len  <= '0;
      r_frame_done <= 1'b0;
      r_proto_err  <= 1'b0;
      r_m_tdata    <= 32'd0;
      r_m_tkeep    <= 4'b0000;
      r_m_tvalid   <= 1'b0;
      r_m_tlast    <= 1'b0;
      r_m_tuser    <= 1'b0;
    end else begin
      r_frame_done <= 1'b0;
      r_proto_err  <= 1'b0;
      if (r_m_tvalid && m_axis_tready) r_m_tvalid <= 1'b0;

      if (w_accept) begin
        r_proto_err <= w_proto;
        if (w_word_end) begin
          r_m_tdata  <= w_word;
          r_m_tkeep  <= w_keep;
          r_m_tvalid <= 1'b1;
          r_m_tlast  <= s_axis_tlast;
          r_m_tuser  <= r_buf_user | s_axis_tuser;
          r_lane     <= 2'd0;
          r_buf_user <= 1'b0;
        end else begin
          case (r_lane)
            2'd0:    r_buf[7:0]   <= s_axis_tdata;
            2'd1:    r_buf[15:8]  <= s_axis_tdata;
            default: r_buf[23:16] <= s_axis_tdata;
          endcase
          r_lane     <= r_lane + 2'd1;
          r_buf_user <= r_buf_user | s_axis_tuser;
        end

        if (s_axis_tlast) begin
          r_frame_len  <= w_cnt_inc;
          r_cnt        <= '0;
          r_frame_done <= 1'b1;
        end else begin
          r_cnt <= w_cnt_inc;
        end
      end
    end
  end

`ifdef JPEG_PACKER_EOI_CHECK_EN
  logic [7:0] r_prev_byte;
  logic       r_have_prev;
  logic       r_eoi_err;

  assign eoi_err = r_eoi_err;

  // A frame must end with FF D9; a 1-byte frame has no predecessor and always fails.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_prev_byte <= 8'd0;
      r_have_prev <= 1'b0;
      r_eoi_err   <= 1'b0;
    end else begin
      r_eoi_err <= 1'b0;
      if (w_accept) begin
        if (s_axis_tlast) begin
          r_eoi_err   <= !(r_have_prev && (r_prev_byte == 8'hFF) && (s_axis_tdata == 8'hD9));
          r_have_prev <= 1'b0;
        end else begin
          r_prev_byte <= s_axis_tdata;
          r_have_prev <= 1'b1;
        end
      end
    end
  end
`else
  assign eoi_err = 1'b0;
`endif

endmodule

// File: tb/tb_jpeg_axis_packer.sv
// tb/tb_jpeg_axis_packer.sv - directed table-driven bench for jpeg_axis_packer (CNT_W=3 to reach saturation)
module tb_jpeg_axis_packer;

  localparam bit Y = 1'b1;
  localparam bit N = 1'b0;
`ifdef JPEG_PACKER_EOI_CHECK_EN
  localparam bit EOI_EN = 1'b1;
`else
  localparam bit EOI_EN = 1'b0;
`endif
  localparam int NV = 21;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  s_axis_tdata;
  logic        s_axis_tvalid;
  logic        s_axis_tready;
  logic        s_axis_tlast;
  logic        s_axis_tuser;
  logic [31:0] m_axis_tdata;
  logic [3:0]  m_axis_tkeep;
  logic        m_axis_tvalid;
  logic        m_axis_tready;
  logic        m_axis_tlast;
  logic        m_axis_tuser;
  logic        frame_done;
  logic [2:0]  frame_len;
  logic        proto_err;
  logic        eoi_err;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  jpeg_axis_packer #(.CNT_W(3)) dut (
    .clk(clk), .rst(rst),
    .s_axis_tdata(s_axis_tdata), .s_axis_tvalid(s_axis_tvalid), .s_axis_tready(s_axis_tready),
    .s_axis_tlast(s_axis_tlast), .s_axis_tuser(s_axis_tuser),
    .m_axis_tdata(m_axis_tdata), .m_axis_tkeep(m_axis_tkeep), .m_axis_tvalid(m_axis_tvalid),
    .m_axis_tready(m_axis_tready), .m_axis_tlast(m_axis_tlast), .m_axis_tuser(m_axis_tuser),
    .frame_done(frame_done), .frame_len(frame_len), .proto_err(proto_err), .eoi_err(eoi_err)
  );

  typedef struct packed {
    logic        v;
    logic [7:0]  d;
    logic        u;
    logic        l;
    logic        ev;
    logic [31:0] ed;
    logic [3:0]  ek;
    logic        el;
    logic        eu;
    logic        edone;
    logic        eperr;
    logic        eeoi;
    logic [2:0]  elen;
  } vec_t;

  vec_t vecs [0:NV-1];

  function automatic vec_t mk(input bit v, input bit [7:0] d, input bit u, input bit l,
                              input bit ev, input bit [31:0] ed, input bit [3:0] ek,
                              input bit el, input bit eu, input bit edone, input bit eperr,
                              input bit eeoi, input bit [2:0] elen);
    vec_t r;
    r.v = v; r.d = d; r.u = u; r.l = l; r.ev = ev; r.ed = ed; r.ek = ek;
    r.el = el; r.eu = eu; r.edone = edone; r.eperr = eperr; r.eeoi = eeoi; r.elen = elen;
    return r;
  endfunction

  task automatic chk1(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%b required=%b", name, act, exp);
    end
  endtask

  task automatic chkw(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%08h required=0x%08h", name, act, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [7:0] d, input logic u, input logic l);
    @(negedge clk);
    s_axis_tvalid = v;
    s_axis_tdata  = d;
    s_axis_tuser  = u;
    s_axis_tlast  = l;
    @(posedge clk);
    #1;
  endtask

  task automatic chk_word(input string name, input logic [31:0] d, input logic [3:0] k,
                          input logic l, input logic u);
    chk1({name, "_mvalid"}, m_axis_tvalid, 1'b1);
    chkw({name, "_tdata"}, m_axis_tdata, d);
    chkw({name, "_tkeep"}, 32'(m_axis_tkeep), 32'(k));
    chk1({name, "_tlast"}, m_axis_tlast, l);
    chk1({name, "_tuser"}, m_axis_tuser, u);
  endtask

  initial begin
    vecs[0]  = mk(Y, 8'hFF, Y, N, N, 32'h0,        4'h0, N, N, N, N, N, 3'd0);
    vecs[1]  = mk(Y, 8'hD8, N, N, N, 32'h0,        4'h0, N, N, N, N, N, 3'd0);
    vecs[2]  = mk(Y, 8'hFF, N, N, N, 32'h0,        4'h0, N, N, N, N, N, 3'd0);
    vecs[3]  = mk(Y, 8'hE0, N, N, Y, 32'hE0FFD8FF, 4'hF, N, Y, N, N, N, 3'd0);
    vecs[4]  = mk(Y, 8'hFF, N, N, N, 32'h0,        4'h0, N, N, N, N, N, 3'd0);
    vecs[5]  = mk(Y, 8'hD9, N, Y, Y, 32'h0000D9FF, 4'h3, Y, N, Y, N, N, 3'd6);
    vecs[6]  = mk(Y, 8'h01, Y, N, N, 32'h0,        4'h0, N, N, N, N, N, 3'd0);
    vecs[7]  = mk(Y, 8'h02, N, N, N, 32'h0,        4'h0, N, N, N, N, N, 3'd0);
    vecs[8]  = mk(Y, 8'h03, N, N, N, 32'h0,        4'h0, N, N, N, N, N, 3'd0);
    vecs[9]  = mk(Y, 8'h04, N, N, Y, 32'h04030201, 4'hF, N, Y, N, N, N, 3'd0);
    vecs[10] = mk(Y, 8'h05, N, N, N, 32'h0,        4'h0, N, N, N, N, N, 3'd0);
    vecs[11] = mk(Y, 8'h06, N, Y, Y, 32'h00000605, 4'h3, Y, N, Y, N, Y, 3'd6);
    vecs[12] = mk(N, 8'h00, N, N, N, 32'h0,        4'h0, N, N, N, N, N, 3'd0);
    vecs[13] = mk(Y, 8'hAA, Y, N, N, 32'h0,        4'h0, N, N, N, N, N, 3'd0);
    vecs[14] = mk(Y, 8'hBB, N, N, N, 32'h0,        4'h0, N, N, N, N, N, 3'd0);
    vecs[15] = mk(Y, 8'hCC, Y, N, N, 32'h0,        4'h0, N, N, N, Y, N, 3'd0);
    vecs[16] = mk(Y, 8'hDD, N, N, Y, 32'hDDCCBBAA, 4'hF, N, Y, N, N, N, 3'd0);
    vecs[17] = mk(Y, 8'hFF, N, N, N, 32'h0,        4'h0, N, N, N, N, N, 3'd0);
    vecs[18] = mk(Y, 8'hD8, N, Y, Y, 32'h0000D8FF, 4'h3, Y, N, Y, N, Y, 3'd6);
    vecs[19] = mk(Y, 8'h11, N, Y, Y, 32'h00000011, 4'h1, Y, N, Y, Y, Y, 3'd1);
    vecs[20] = mk(Y, 8'h22, Y, Y, Y, 32'h00000022, 4'h1, Y, Y, Y, N, Y, 3'd1);

    rst = 1'b1;
    s_axis_tvalid = 1'b0; s_axis_tdata = 8'h00; s_axis_tuser = 1'b0; s_axis_tlast = 1'b0;
    m_axis_tready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk1("rst_mvalid", m_axis_tvalid, 1'b0);
    chkw("rst_tdata", m_axis_tdata, 32'h0);
    chkw("rst_tkeep", 32'(m_axis_tkeep), 32'h0);
    chk1("rst_tlast", m_axis_tlast, 1'b0);
    chk1("rst_tuser", m_axis_tuser, 1'b0);
    chk1("rst_done", frame_done, 1'b0);
    chk1("rst_perr", proto_err, 1'b0);
    chk1("rst_eoi", eoi_err, 1'b0);
    chkw("rst_len", 32'(frame_len), 32'h0);
    chk1("rst_stready", s_axis_tready, 1'b1);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < NV; i++) begin
      drive(vecs[i].v, vecs[i].d, vecs[i].u, vecs[i].l);
      chk1($sformatf("v%0d_mvalid", i), m_axis_tvalid, vecs[i].ev);
      if (vecs[i].ev) begin
        chkw($sformatf("v%0d_tdata", i), m_axis_tdata, vecs[i].ed);
        chkw($sformatf("v%0d_tkeep", i), 32'(m_axis_tkeep), 32'(vecs[i].ek));
        chk1($sformatf("v%0d_tlast", i), m_axis_tlast, vecs[i].el);
        chk1($sformatf("v%0d_tuser", i), m_axis_tuser, vecs[i].eu);
      end
      chk1($sformatf("v%0d_done", i), frame_done, vecs[i].edone);
      if (vecs[i].edone) chkw($sformatf("v%0d_len", i), 32'(frame_len), 32'(vecs[i].elen));
      chk1($sformatf("v%0d_perr", i), proto_err, vecs[i].eperr);
      chk1($sformatf("v%0d_eoi", i), eoi_err, vecs[i].eeoi & EOI_EN);
      chk1($sformatf("v%0d_stready", i), s_axis_tready, 1'b1);
    end

    // Backpressure: a full word stalls for 10 cycles with the next byte waiting.
    drive(N, 8'h00, N, N);
    m_axis_tready = 1'b0;
    drive(Y, 8'hA0, Y, N);
    drive(Y, 8'hA1, N, N);
    drive(Y, 8'hA2, N, N);
    drive(Y, 8'hA3, N, N);
    chk_word("bp_first", 32'hA3A2A1A0, 4'hF, 1'b0, 1'b1);
    for (int c = 0; c < 10; c++) begin
      drive(Y, 8'hB0, N, N);
      chk1($sformatf("bp_stall%0d_stready", c), s_axis_tready, 1'b0);
      chk1($sformatf("bp_stall%0d_mvalid", c), m_axis_tvalid, 1'b1);
      chkw($sformatf("bp_stall%0d_tdata", c), m_axis_tdata, 32'hA3A2A1A0);
    end
    m_axis_tready = 1'b1;
    drive(Y, 8'hB0, N, N);
    chk1("bp_drain_mvalid", m_axis_tvalid, 1'b0);
    drive(Y, 8'hB1, N, N);
    drive(Y, 8'hB2, N, N);
    drive(Y, 8'hB3, N, Y);
    chk_word("bp_last", 32'hB3B2B1B0, 4'hF, 1'b1, 1'b0);
    chk1("bp_done", frame_done, 1'b1);
    chkw("bp_len_sat", 32'(frame_len), 32'd7);
    chk1("bp_eoi", eoi_err, EOI_EN);

    // Reset two bytes into a frame, then a fresh frame must start at lane 0.
    drive(N, 8'h00, N, N);
    drive(Y, 8'hC0, Y, N);
    drive(Y, 8'hC1, N, N);
    @(negedge clk);
    rst = 1'b1;
    s_axis_tvalid = 1'b0;
    @(posedge clk);
    #1;
    chk1("mid_rst_mvalid", m_axis_tvalid, 1'b0);
    chkw("mid_rst_tdata", m_axis_tdata, 32'h0);
    chkw("mid_rst_tkeep", 32'(m_axis_tkeep), 32'h0);
    chk1("mid_rst_done", frame_done, 1'b0);
    chkw("mid_rst_len", 32'(frame_len), 32'h0);
    chk1("mid_rst_stready", s_axis_tready, 1'b1);
    @(negedge clk);
    rst = 1'b0;
    drive(N, 8'h00, N, N);
    chk1("post_rst_idle0_mvalid", m_axis_tvalid, 1'b0);
    drive(N, 8'h00, N, N);
    chk1("post_rst_idle1_mvalid", m_axis_tvalid, 1'b0);
    drive(Y, 8'hD0, Y, N);
    chk1("post_rst_d0_perr", proto_err, 1'b0);
    drive(Y, 8'hD1, N, N);
    drive(Y, 8'hD2, N, N);
    drive(Y, 8'hD3, N, Y);
    chk_word("post_rst_word", 32'hD3D2D1D0, 4'hF, 1'b1, 1'b1);
    chkw("post_rst_len", 32'(frame_len), 32'd4);
    chk1("post_rst_done", frame_done, 1'b1);
    drive(N, 8'h00, N, N);
    chk1("post_rst_done_pulse", frame_done, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/jpeg_axis_packer.md
JPEG_AXIS_PACKER -- requirements
Module: jpeg_axis_packer

Interface
REQ-001 SHALL have parameter CNT_W, default 24, meaning width of the frame byte counter.
REQ-002 SHALL have port clk  input  1  single clock; all logic rising-edge.
REQ-003 SHALL have port rst  input  1  reset; one clock; reset is synchronous and active-high.
REQ-004 SHALL have ports s_axis_tdata/tvalid/tready/tlast/tuser  in/in/out/in/in  8/1/1/1/1  JPEG byte stream from the encoder; tuser marks the frame's first byte, tlast its last byte.
REQ-005 SHALL have ports m_axis_tdata/tkeep/tvalid/tready/tlast/tuser  out/out/out/in/out/out  32/4/1/1/1/1  packed word stream for the DMA.
REQ-006 SHALL have port frame_done  output  1  one-cycle pulse when a frame's last byte is accepted.
REQ-007 SHALL have port frame_len  output  CNT_W  byte count of the last completed frame.
REQ-008 SHALL have port proto_err  output  1  one-cycle pulse on input protocol violation.
REQ-009 SHALL have port eoi_err  output  1  one-cycle pulse; end-of-image check failure; see Configuration.

Function
REQ-010 SHALL accept a byte when s_axis_tvalid && s_axis_tready; s_axis_tready = !out_valid || m_axis_tready.
REQ-011 SHALL place accepted bytes little-endian: first byte of a word in [7:0], fourth in [31:24]; lane index 0..3 wraps 3->0.
REQ-012 SHALL load the output register in the cycle after the byte filling lane 3, or after a tlast byte in any lane; latency is 1 cycle from that accept to m_axis_tvalid.
REQ-013 SHALL drive tkeep contiguous from lane 0: lanes 0..n-1 set for n valid bytes (0001, 0011, 0111, 1111); unused lanes in tdata are zero.
REQ-014 SHALL assert m_axis_tlast only on the word holding the tlast byte; m_axis_tuser only on the word holding the tuser byte.
REQ-015 SHALL hold m_axis_tdata/tkeep/tlast/tuser stable while m_axis_tvalid && !m_axis_tready.
REQ-016 SHALL support back-to-back full words at one byte per cycle with no bubbles when m_axis_tready stays high.
REQ-017 SHALL implement states IDLE (no frame open) and IN_FRAME; IDLE->IN_FRAME on accepted byte without tlast; IN_FRAME->IDLE on accepted tlast byte; a single byte with tuser and tlast stays in IDLE and emits one word.
REQ-018 SHALL count accepted bytes per frame; on the tlast accept, frame_len <= count+1 and frame_done pulses the next cycle; the counter clears to 0.
REQ-019 SHALL saturate the counter at 2^CNT_W-1 without wrapping.
REQ-020 SHALL pulse proto_err, and still pack the byte normally, when tuser arrives in IN_FRAME or lane != 0, or when a byte without tuser arrives in IDLE.
REQ-021 SHALL accept no byte while out_valid && !m_axis_tready, including simultaneous tlast input.

Reset
REQ-022 SHALL on rst clear: m_axis_tvalid, tlast, tuser, frame_done, proto_err, eoi_err = 0; m_axis_tdata = 0, tkeep = 0; frame_len = 0; lane = 0; counter = 0; state = IDLE; s_axis_tready = 1 in the first cycle after reset.
REQ-023 SHALL discard partial words and a pending output word on rst mid-frame; no output beat after reset until new input.

Configuration
REQ-024 SHALL, with JPEG_PACKER_EOI_CHECK_EN defined, track the last two accepted bytes and pulse eoi_err with frame_done when they are not FF D9, including 1-byte frames.
REQ-025 SHALL, with JPEG_PACKER_EOI_CHECK_EN undefined, tie eoi_err to 0 and omit the tracking registers; all other behaviour is identical.

Verification
REQ-026 SHALL cover: bytes FF D8 FF E0 (tuser on first), m_tready=1 -> one word 0xE0FFD8FF, tkeep 1111, tuser 1.
REQ-027 SHALL cover: 6-byte frame 01..06, tlast on 06 -> 0x04030201/1111, then 0x00000605/0011 tlast 1; frame_len=6, frame_done pulse.
REQ-028 SHALL cover: m_tready low 10 cycles mid-frame -> output word stable, s_tready=0, no byte lost or duplicated.
REQ-029 SHALL cover: frame ending ..FF D9 and ..FF D8 with macro defined -> eoi_err 0 then 1; macro undefined -> always 0.
REQ-030 SHALL cover: tuser on the third byte of a frame -> proto_err one pulse, data packed unchanged.
REQ-031 SHALL cover: rst asserted after 2 bytes of a frame -> all outputs at reset values, next frame packed from lane 0.
